// File: rtl/fpga_robots_game_led_sequencer.sv
// Multi-channel LED pattern sequencer: per-channel LOOP/ONESHOT/STEADY patterns
// with PWM brightness, advanced on a shared prescaler tick.
module fpga_robots_game_led_sequencer #(
  parameter int NCH           = 4,
  parameter int STEPS         = 16,
  parameter int PRESCALE_BITS = 22,
  parameter int PWM_BITS      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_wen,
  input  logic [3:0]          cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [STEPS-1:0]    cfg_pattern,
  input  logic [PWM_BITS-1:0] cfg_bright,
  input  logic [NCH-1:0]      trig,
  output logic [NCH-1:0]      led,
  output logic [NCH-1:0]      busy,
  output logic                step_tick
);

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_LOOP    = 2'd1,
    M_ONESHOT = 2'd2,
    M_STEADY  = 2'd3
  } mode_t;

  localparam int SW = $clog2(STEPS + 1);
  localparam logic [STEPS-1:0] HB_PAT = STEPS'(16'h0011);

  logic [PRESCALE_BITS-1:0] pre_ctr;
  logic [PWM_BITS-1:0]      pwm_ctr;
  logic                     tick;

  mode_t               mode   [NCH];
  logic [STEPS-1:0]    pat    [NCH];
  logic [STEPS-1:0]    work   [NCH];
  logic [PWM_BITS-1:0] bright [NCH];
  logic [SW-1:0]       step   [NCH];

  logic [NCH-1:0] lit;
  logic [NCH-1:0] led_d;

  always_comb begin
    tick = (pre_ctr == '1);
  end

  always_comb begin
    lit = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      case (mode[i])
        M_OFF:     lit[i] = 1'b0;
        M_STEADY:  lit[i] = 1'b1;
        M_LOOP:    lit[i] = work[i][0];
        M_ONESHOT: lit[i] = busy[i] & work[i][0];
        default:   lit[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      led_d[i] = lit[i] & ((pwm_ctr < bright[i]) | (&bright[i]));
    end
  end

  // Per-channel priority: config write, then trig, then tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_ctr   <= '0;
      pwm_ctr   <= '0;
      step_tick <= 1'b0;
      led       <= '0;
      busy      <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        mode[i]   <= (i == 0) ? M_LOOP : M_OFF;
        pat[i]    <= (i == 0) ? HB_PAT : '0;
        work[i]   <= (i == 0) ? HB_PAT : '0;
        bright[i] <= (i == 0) ? '1 : '0;
        step[i]   <= '0;
      end
    end else begin
      pre_ctr   <= pre_ctr + 1'b1;
      pwm_ctr   <= pwm_ctr + 1'b1;
      step_tick <= tick;
      led       <= led_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cfg_wen && (32'(cfg_ch) == i)) begin
          mode[i]   <= mode_t'(cfg_mode);
          pat[i]    <= cfg_pattern;
          bright[i] <= cfg_bright;
          work[i]   <= cfg_pattern;
          step[i]   <= '0;
          busy[i]   <= 1'b0;
        end else if (trig[i] && (mode[i] == M_ONESHOT)) begin
          work[i] <= pat[i];
          step[i] <= '0;
          busy[i] <= 1'b1;
        end else if (tick) begin
          if (mode[i] == M_LOOP) begin
            work[i] <= {work[i][0], work[i][STEPS-1:1]};
          end else if ((mode[i] == M_ONESHOT) && busy[i]) begin
            work[i] <= work[i] >> 1;
            if (step[i] == SW'(STEPS - 1)) begin
              busy[i] <= 1'b0;
              step[i] <= '0;
            end else begin
              step[i] <= step[i] + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_led_sequencer.sv
// Randomised and directed bench for the LED sequencer against a position-based
// reference model of the channel patterns.
module tb_fpga_robots_game_led_sequencer;

  localparam int NCH   = 4;
  localparam int STEPS = 16;
  localparam int PB    = 4;
  localparam int PW    = 4;
  localparam int TPER  = 1 << PB;
  localparam int PPER  = 1 << PW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_wen = 1'b0;
  logic [3:0]      cfg_ch = '0;
  logic [1:0]      cfg_mode = '0;
  logic [STEPS-1:0] cfg_pattern = '0;
  logic [PW-1:0]   cfg_bright = '0;
  logic [NCH-1:0]  trig = '0;
  logic [NCH-1:0]  led;
  logic [NCH-1:0]  busy;
  logic            step_tick;

  fpga_robots_game_led_sequencer #(
    .NCH(NCH), .STEPS(STEPS), .PRESCALE_BITS(PB), .PWM_BITS(PW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wen(cfg_wen), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern), .cfg_bright(cfg_bright),
    .trig(trig), .led(led), .busy(busy), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  // Reference model: pattern index reached rather than a shifting register.
  int               m_mode   [NCH];
  logic [STEPS-1:0] m_pat    [NCH];
  int               m_bright [NCH];
  int               m_pos    [NCH];
  bit               m_busy   [NCH];
  int               m_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < NCH; i++) begin
      m_mode[i]   = (i == 0) ? 1 : 0;
      m_pat[i]    = (i == 0) ? 16'h0011 : '0;
      m_bright[i] = (i == 0) ? PPER - 1 : 0;
      m_pos[i]    = 0;
      m_busy[i]   = 1'b0;
    end
  endtask

  task automatic cycle();
    logic [NCH-1:0] e_led;
    logic [NCH-1:0] e_busy;
    logic           e_tick;
    bit             tk;
    bit             l;
    int             pw;
    tk = ((m_cnt % TPER) == TPER - 1);
    pw = m_cnt % PPER;
    e_led = '0;
    for (int i = 0; i < NCH; i++) begin
      case (m_mode[i])
        1:       l = m_pat[i][m_pos[i]];
        2:       l = m_busy[i] && m_pat[i][m_pos[i]];
        3:       l = 1'b1;
        default: l = 1'b0;
      endcase
      e_led[i] = !rst && l && ((pw < m_bright[i]) || (m_bright[i] == PPER - 1));
    end
    if (rst) begin
      model_reset();
      e_tick = 1'b0;
    end else begin
      e_tick = tk;
      for (int i = 0; i < NCH; i++) begin
        if (cfg_wen && (int'(cfg_ch) == i)) begin
          m_mode[i] = int'(cfg_mode); m_pat[i] = cfg_pattern;
          m_bright[i] = int'(cfg_bright); m_pos[i] = 0; m_busy[i] = 1'b0;
        end else if (trig[i] && m_mode[i] == 2) begin
          m_pos[i] = 0; m_busy[i] = 1'b1;
        end else if (tk) begin
          if (m_mode[i] == 1) m_pos[i] = (m_pos[i] + 1) % STEPS;
          else if (m_mode[i] == 2 && m_busy[i]) begin
            m_pos[i]++;
            if (m_pos[i] == STEPS) begin m_pos[i] = 0; m_busy[i] = 1'b0; end
          end
        end
      end
      m_cnt++;
    end
    for (int i = 0; i < NCH; i++) e_busy[i] = m_busy[i];
    @(posedge clk);
    #1;
    check("led", 32'(led), 32'(e_led));
    check("busy", 32'(busy), 32'(e_busy));
    check("step_tick", 32'(step_tick), 32'(e_tick));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic write_cfg(input int ch, input int md, input logic [STEPS-1:0] p,
                           input int br, input logic [NCH-1:0] tg);
    cfg_wen = 1'b1; cfg_ch = 4'(ch); cfg_mode = 2'(md);
    cfg_pattern = p; cfg_bright = PW'(br); trig = tg;
    cycle();
    cfg_wen = 1'b0; trig = '0;
  endtask

  task automatic pulse_trig(input logic [NCH-1:0] tg);
    trig = tg;
    cycle();
    trig = '0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(520);                                   // heartbeat, two full periods
    write_cfg(1, 1, 16'h00FF, 15, '0);
    run(300);
    write_cfg(2, 2, 16'hFFFF, 15, '0);
    pulse_trig(4'b0100);
    run(TPER * 5);
    pulse_trig(4'b0100);                        // restart mid-run
    run(TPER * 23);
    write_cfg(3, 3, '1, 4, '0);
    run(48);
    write_cfg(3, 3, '1, 0, '0);
    run(32);
    write_cfg(3, 3, '1, 15, '0);
    run(32);
    while ((m_cnt % TPER) != TPER - 1) cycle();
    write_cfg(1, 1, 16'h0F0F, 15, '0);         // write on a tick
    run(40);
    write_cfg(1, 2, 16'hAAAA, 15, '0);
    pulse_trig(4'b0010);
    run(40);
    write_cfg(1, 2, 16'h5555, 15, 4'b0010);    // write with trig
    run(40);
    write_cfg(5, 3, '1, 15, '0);               // out-of-range channel
    run(40);
    write_cfg(2, 2, 16'hFFFF, 15, '0);
    pulse_trig(4'b0100);
    run(40);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(300);
    for (int k = 0; k < 4000; k++) begin
      cfg_wen     = ($urandom_range(0, 29) == 0);
      cfg_ch      = 4'($urandom_range(0, 5));
      cfg_mode    = 2'($urandom);
      cfg_pattern = STEPS'($urandom);
      cfg_bright  = PW'($urandom);
      trig        = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
      rst         = ($urandom_range(0, 1499) == 0);
      cycle();
    end
    cfg_wen = 1'b0; trig = '0; rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
